// File: rtl/split_assign_loader.sv
// Word-stream loader for a split_* constraint checker: assembles a packed assignment,
// strobes one evaluation, returns the verdict on a valid/ready channel.
// Optional pass/fail statistics are enabled by defining SPLIT_LOADER_STATS_EN.
module split_assign_loader #(
  parameter int TOTAL_W = 368,
  parameter int WORD_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  output logic [TOTAL_W-1:0] assign_bus,
  output logic               assign_vld,
  input  logic               chk_x,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_pass,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic [CNT_W-1:0]   fail_cnt
);

  localparam int NWORDS = (TOTAL_W + WORD_W - 1) / WORD_W;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {LOAD, EVAL, REPORT} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             accept;

  assign accept = in_valid && in_ready;

  // in_ready is a flop so it reads 0 while rst is held and rises one edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD;
      idx        <= '0;
      assign_bus <= '0;
      assign_vld <= 1'b0;
      in_ready   <= 1'b0;
      res_valid  <= 1'b0;
      res_pass   <= 1'b0;
    end else begin
      assign_vld <= 1'b0;
      case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (accept) begin
            // Bits of the last word beyond TOTAL_W have no destination and are dropped.
            for (int b = 0; b < TOTAL_W; b++) begin
              if (b / WORD_W == int'(idx)) assign_bus[b] <= in_data[b % WORD_W];
            end
            if (idx == LAST_IDX) begin
              state      <= EVAL;
              in_ready   <= 1'b0;
              assign_vld <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        EVAL: begin
          res_pass  <= chk_x;
          res_valid <= 1'b1;
          state     <= REPORT;
        end
        REPORT: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            idx       <= '0;
            in_ready  <= 1'b1;
            state     <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

`ifdef SPLIT_LOADER_STATS_EN
  // Saturating counters, updated once per result handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (res_valid && res_ready) begin
      if (res_pass) begin
        if (pass_cnt != {CNT_W{1'b1}}) pass_cnt <= pass_cnt + 1'b1;
      end else begin
        if (fail_cnt != {CNT_W{1'b1}}) fail_cnt <= fail_cnt + 1'b1;
      end
    end
  end
`else
  assign pass_cnt = '0;
  assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_split_assign_loader.sv
// Directed self-checking bench for split_assign_loader (TOTAL_W=368, WORD_W=32, CNT_W=2).
module tb_split_assign_loader;
  localparam int TOTAL_W = 368;
  localparam int WORD_W  = 32;
  localparam int CNT_W   = 2;
  localparam int NWORDS  = 12;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WORD_W-1:0]  in_data = '0;
  logic [TOTAL_W-1:0] assign_bus;
  logic               assign_vld;
  logic               chk_x = 1'b0;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic               res_pass;
  logic [CNT_W-1:0]   pass_cnt;
  logic [CNT_W-1:0]   fail_cnt;

  int checks = 0;
  int errors = 0;
  int vld_cnt = 0;
  int acc_cnt = 0;
  logic [TOTAL_W-1:0] exp_bus = '0;

  split_assign_loader #(.TOTAL_W(TOTAL_W), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .assign_bus(assign_bus), .assign_vld(assign_vld), .chk_x(chk_x),
    .res_valid(res_valid), .res_ready(res_ready), .res_pass(res_pass),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (assign_vld) vld_cnt++;
    if (in_valid && in_ready) acc_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends NWORDS words (base + k*step), optionally on alternate cycles; builds exp_bus.
  task automatic send_words(input logic [31:0] base, input logic [31:0] step, input bit gap);
    int sent = 0;
    logic acc;
    logic [NWORDS*WORD_W-1:0] wide = '0;
    for (int c = 0; c < 100 && sent < NWORDS; c++) begin
      in_valid = !gap || (c % 2 == 0);
      in_data  = base + step * 32'(sent);
      acc = in_valid && in_ready;
      if (acc) wide[sent*WORD_W +: WORD_W] = in_data;
      tick();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    exp_bus = wide[TOTAL_W-1:0];
    checks++;
    if (sent != NWORDS) begin
      errors++;
      $display("FAIL send_timeout: accepted %0d words, required %0d", sent, NWORDS);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
    checks++; if (assign_bus !== '0) begin errors++; $display("FAIL rst_bus: got %h want 0", assign_bus); end
    in_valid = 1'b1; in_data = 32'h5555_5555;
    tick(); tick(); tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, assign_vld, res_valid, res_pass} !== 4'b0 || assign_bus !== '0 ||
        pass_cnt !== '0 || fail_cnt !== '0) begin
      errors++;
      $display("FAIL async_rst_outputs: rdy=%b vld=%b rv=%b rp=%b bus=%h pc=%0d fc=%0d want all 0",
               in_ready, assign_vld, res_valid, res_pass, assign_bus, pass_cnt, fail_cnt);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rel_res_valid: got %b want 0", res_valid); end
  endtask

  task automatic test_single_load();
    int v0;
    res_ready = 1'b0;
    chk_x = 1'b1;
    v0 = vld_cnt;
    send_words(32'h1, 32'h1, 1'b0);
    checks++; if (assign_vld !== 1'b1) begin errors++; $display("FAIL sl_vld_rise: got %b want 1", assign_vld); end
    checks++; if (assign_bus[31:0] !== 32'h1) begin errors++; $display("FAIL sl_word0: got %h want 00000001", assign_bus[31:0]); end
    checks++; if (assign_bus[367:352] !== 16'h000C) begin errors++; $display("FAIL sl_word11: got %h want 000c", assign_bus[367:352]); end
    checks++; if (assign_bus !== exp_bus) begin errors++; $display("FAIL sl_bus: got %h want %h", assign_bus, exp_bus); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sl_eval_ready: got %b want 0", in_ready); end
    tick();
    checks++; if (assign_vld !== 1'b0) begin errors++; $display("FAIL sl_vld_fall: got %b want 0", assign_vld); end
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL sl_res_valid: got %b want 1", res_valid); end
    checks++; if (res_pass !== 1'b1) begin errors++; $display("FAIL sl_res_pass: got %b want 1", res_pass); end
    checks++; if (vld_cnt - v0 != 1) begin errors++; $display("FAIL sl_vld_pulses: got %0d want 1", vld_cnt - v0); end
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (res_valid !== 1'b1 || in_ready !== 1'b0 || res_pass !== 1'b1 || assign_bus !== exp_bus) begin
        errors++;
        $display("FAIL bp_hold[%0d]: rv=%b rdy=%b rp=%b bus_ok=%b want rv=1 rdy=0 rp=1 bus_ok=1",
                 i, res_valid, in_ready, res_pass, assign_bus === exp_bus);
      end
    end
    res_ready = 1'b1;
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_release_rv: got %b want 0", res_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_rdy: got %b want 1", in_ready); end
  endtask

  task automatic test_gapped();
    int v0, a0;
    chk_x = 1'b0;
    res_ready = 1'b1;
    v0 = vld_cnt; a0 = acc_cnt;
    send_words(32'hA000_0000, 32'h0000_1111, 1'b1);
    checks++; if (assign_vld !== 1'b1) begin errors++; $display("FAIL gap_vld: got %b want 1", assign_vld); end
    checks++; if (acc_cnt - a0 != NWORDS) begin errors++; $display("FAIL gap_accepts: got %0d want %0d", acc_cnt - a0, NWORDS); end
    checks++; if (vld_cnt - v0 != 0) begin errors++; $display("FAIL gap_early_vld: got %0d want 0", vld_cnt - v0); end
    checks++; if (assign_bus !== exp_bus) begin errors++; $display("FAIL gap_bus: got %h want %h", assign_bus, exp_bus); end
    tick();
    checks++; if (res_valid !== 1'b1 || res_pass !== 1'b0) begin errors++; $display("FAIL gap_result: rv=%b rp=%b want rv=1 rp=0", res_valid, res_pass); end
    tick();
    checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL gap_done: rv=%b rdy=%b want rv=0 rdy=1", res_valid, in_ready); end
  endtask

  task automatic test_mid_load_reset();
    int v0;
    chk_x = 1'b1;
    res_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h1234_5678;
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    v0 = vld_cnt;
    send_words(32'hFFFF_FFFF, 32'h0, 1'b0);
    checks++; if (assign_bus !== {TOTAL_W{1'b1}}) begin errors++; $display("FAIL mlr_bus: got %h want all ones", assign_bus); end
    checks++; if (assign_vld !== 1'b1) begin errors++; $display("FAIL mlr_vld: got %b want 1", assign_vld); end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (vld_cnt - v0 != 1) begin errors++; $display("FAIL mlr_vld_pulses: got %0d want 1", vld_cnt - v0); end
  endtask

  task automatic run_one(input logic verdict, input logic [31:0] base);
    chk_x = verdict;
    res_ready = 1'b1;
    send_words(base, 32'h3, 1'b0);
    tick();
    tick();
  endtask

  task automatic test_stats();
    logic [CNT_W-1:0] exp_p, exp_f;
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    run_one(1'b1, 32'h10);
    run_one(1'b1, 32'h20);
`ifdef SPLIT_LOADER_STATS_EN
    exp_p = 2'd2;
`else
    exp_p = 2'd0;
`endif
    checks++; if (pass_cnt !== exp_p) begin errors++; $display("FAIL stats_pass_mid: got %0d want %0d", pass_cnt, exp_p); end
    run_one(1'b1, 32'h30);
    run_one(1'b1, 32'h40);
    run_one(1'b0, 32'h50);
    run_one(1'b0, 32'h60);
`ifdef SPLIT_LOADER_STATS_EN
    exp_p = 2'd3; exp_f = 2'd2;
`else
    exp_p = 2'd0; exp_f = 2'd0;
`endif
    checks++; if (pass_cnt !== exp_p) begin errors++; $display("FAIL stats_pass: got %0d want %0d", pass_cnt, exp_p); end
    checks++; if (fail_cnt !== exp_f) begin errors++; $display("FAIL stats_fail: got %0d want %0d", fail_cnt, exp_f); end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_backpressure();
    test_gapped();
    test_mid_load_reset();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
